// File: rtl/phrase_sequencer.sv
// Sends the enabled ROM segments as one phrase, one serializer character at a time; PHRASE_SEPARATOR_EN adds an 8'h20 between segments.
// Triggers are accepted only in IDLE and never queued; each character waits for tx_busy to fall plus CHAR_GAP idle cycles.
`timescale 1ns/1ps
module phrase_sequencer #(
  parameter int SEL_W = 4,
  parameter int ADDR_W = 6,
  parameter logic [SEL_W*ADDR_W-1:0] SEG_BASE = {6'd31, 6'd23, 6'd12, 6'd0},
  parameter logic [SEL_W*ADDR_W-1:0] SEG_LEN = {6'd5, 6'd8, 6'd11, 6'd12},
  parameter int CHAR_GAP = 78105,
  parameter int AUTO_PERIOD = 2**25
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic              write_pls,
  input  logic              auto_pls,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              auto_on
);

  localparam int SW = $clog2(SEL_W + 1);
  localparam int GW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_FETCH, ST_SEND, ST_WAIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SW-1:0]     seg_idx_q, seg_idx_d;
  logic [ADDR_W-1:0] char_idx_q, char_idx_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              gap_ph_q, gap_ph_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic [AW-1:0]     auto_cnt_q, auto_cnt_d;
  logic              auto_on_q, auto_on_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
`ifdef PHRASE_SEPARATOR_EN
  logic              sep_q, sep_d;
  logic              sent_any_q, sent_any_d;
`endif

  logic              auto_tick, trigger, found, gap_done;
  logic [SW-1:0]     found_idx;
  logic [ADDR_W-1:0] char_next;

  function automatic logic [ADDR_W-1:0] seg_base(input logic [SW-1:0] idx);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < SEL_W; i++)
      if (idx == SW'(i)) r = SEG_BASE[i*ADDR_W +: ADDR_W];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] seg_len(input logic [SW-1:0] idx);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < SEL_W; i++)
      if (idx == SW'(i)) r = SEG_LEN[i*ADDR_W +: ADDR_W];
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    seg_idx_d  = seg_idx_q;
    char_idx_d = char_idx_q;
    gap_cnt_d  = gap_cnt_q;
    gap_ph_d   = gap_ph_q;
    fetch_ph_d = fetch_ph_q;
    auto_cnt_d = auto_cnt_q;
    auto_on_d  = auto_on_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    rom_addr_d = rom_addr_q;
`ifdef PHRASE_SEPARATOR_EN
    sep_d      = sep_q;
    sent_any_d = sent_any_q;
`endif
    gap_done   = 1'b0;
    char_next  = char_idx_q + ADDR_W'(1);

    auto_tick = auto_on_q && (auto_cnt_q == AW'(AUTO_PERIOD - 1));
    trigger   = write_pls || auto_tick;

    // Lowest enabled non-empty segment at or above seg_idx; one hop per SCAN cycle.
    found     = 1'b0;
    found_idx = '0;
    for (int i = SEL_W - 1; i >= 0; i--) begin
      if (SW'(i) >= seg_idx_q && sel_q[i] && SEG_LEN[i*ADDR_W +: ADDR_W] != '0) begin
        found     = 1'b1;
        found_idx = SW'(i);
      end
    end

    if (auto_pls) begin
      auto_on_d  = ~auto_on_q;
      auto_cnt_d = '0;
    end else if (auto_on_q) begin
      auto_cnt_d = auto_tick ? '0 : auto_cnt_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          sel_d      = sel;
          seg_idx_d  = '0;
          char_idx_d = '0;
          busy_d     = 1'b1;
`ifdef PHRASE_SEPARATOR_EN
          sent_any_d = 1'b0;
`endif
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (found) begin
          seg_idx_d  = found_idx;
          char_idx_d = '0;
`ifdef PHRASE_SEPARATOR_EN
          if (sent_any_q) begin
            sep_d      = 1'b1;
            tx_data_d  = 8'h20;
            tx_start_d = 1'b1;
            state_d    = ST_SEND;
          end else
`endif
          begin
            rom_addr_d = seg_base(found_idx);
            fetch_ph_d = 1'b0;
            state_d    = ST_FETCH;
          end
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_FETCH: begin
        // First cycle lets the ROM see the new address; data is captured on the second.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          tx_data_d  = rom_data;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        gap_ph_d  = 1'b0;
        gap_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (!gap_ph_q) begin
          if (!tx_busy) begin
            if (CHAR_GAP == 0) begin
              gap_done = 1'b1;
            end else begin
              gap_ph_d  = 1'b1;
              gap_cnt_d = '0;
            end
          end
        end else if (gap_cnt_q == GW'(CHAR_GAP - 1)) begin
          gap_done = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end

        if (gap_done) begin
`ifdef PHRASE_SEPARATOR_EN
          if (sep_q) begin
            sep_d      = 1'b0;
            rom_addr_d = seg_base(seg_idx_q);
            fetch_ph_d = 1'b0;
            state_d    = ST_FETCH;
          end else
`endif
          begin
            if (char_next == seg_len(seg_idx_q)) begin
              char_idx_d = '0;
              seg_idx_d  = seg_idx_q + SW'(1);
`ifdef PHRASE_SEPARATOR_EN
              sent_any_d = 1'b1;
`endif
              state_d    = ST_SCAN;
            end else begin
              char_idx_d = char_next;
              rom_addr_d = seg_base(seg_idx_q) + char_next;
              fetch_ph_d = 1'b0;
              state_d    = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      seg_idx_q  <= '0;
      char_idx_q <= '0;
      gap_cnt_q  <= '0;
      gap_ph_q   <= 1'b0;
      fetch_ph_q <= 1'b0;
      auto_cnt_q <= '0;
      auto_on_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      rom_addr_q <= '0;
`ifdef PHRASE_SEPARATOR_EN
      sep_q      <= 1'b0;
      sent_any_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      seg_idx_q  <= seg_idx_d;
      char_idx_q <= char_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      gap_ph_q   <= gap_ph_d;
      fetch_ph_q <= fetch_ph_d;
      auto_cnt_q <= auto_cnt_d;
      auto_on_q  <= auto_on_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rom_addr_q <= rom_addr_d;
`ifdef PHRASE_SEPARATOR_EN
      sep_q      <= sep_d;
      sent_any_q <= sent_any_d;
`endif
    end
  end

  assign rom_addr = rom_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign auto_on  = auto_on_q;

endmodule
